// File: rtl/fifo_rd_sched.sv
// Read-side burst scheduler: round-robin grant between two requesters,
// streams granted burst words out of a FIFO one word per non-empty cycle.
module fifo_rd_sched #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 3
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              empty,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [1:0]        req,
  input  logic [LEN_W-1:0]  burst_len0,
  input  logic [LEN_W-1:0]  burst_len1,
  output logic              rd_inc,
  output logic [1:0]        gnt,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_valid,
  output logic [1:0]        done,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  state_t           state;
  logic [LEN_W:0]   cnt;
  logic             last;
  logic             live;
  logic             win1;
  logic [LEN_W-1:0] win_len;
  logic [LEN_W:0]   load_cnt;

  assign live   = |(req & gnt);
  assign rd_inc = (state == XFER) & ~empty & live;
  assign busy   = (state != IDLE);

  // requester 1 wins alone, or on a tie when requester 0 was served last
  assign win1     = req[1] & (~req[0] | ~last);
  assign win_len  = win1 ? burst_len1 : burst_len0;
  assign load_cnt = {(win_len == '0), win_len};

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      state     <= IDLE;
      gnt       <= '0;
      out_valid <= '0;
      out_data  <= '0;
      done      <= '0;
      cnt       <= '0;
      last      <= 1'b1;
    end else begin
      out_valid <= rd_inc ? gnt : 2'b00;
      if (rd_inc) out_data <= rd_data;
      done <= '0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= win1 ? 2'b10 : 2'b01;
            cnt   <= load_cnt;
            state <= XFER;
          end
        end
        XFER: begin
          if (!live) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= gnt[1];
          end else if (rd_inc) begin
            cnt <= cnt - 1'b1;
            if (cnt == {{LEN_W{1'b0}}, 1'b1}) begin
              state <= DONE;
              gnt   <= '0;
              done  <= gnt;
            end
          end
        end
        DONE: begin
          last  <= done[1];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
